pipe_dbg_ctrl: RTL and testbench
================================

Name: pipe_dbg_ctrl

Overview:
- UART-driven debug sequencer for the 5-stage MIPS pipeline.
- Decodes single-byte commands from uart_rx and gates the pipeline clock enable to run, pause or single-step.
- Latches a snapshot of selected pipeline signals and streams it as a framed byte packet into the TX char FIFO that feeds uart_tx.
- Sits between uart_rx, the char FIFO write port and the Pipeline top.

Parameters:
- NUM_WORDS, 8: number of 32-bit snapshot words per dump, range 1..16.
- RST_CYCLES, 4: length of the pipeline reset pulse in clk cycles, range 1..15.
- HDR_BYTE, 8'hA5: first byte of every dump packet.
- TRL_BYTE, 8'h5A: last byte of every dump packet.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  command byte from uart_rx.
- rx_data_rdy  in  1  uart_rx ready level; a command is accepted on its rising edge.
- snap_in  in  NUM_WORDS*32  snapshot words; word 0 in bits [31:0].
- fifo_full  in  1  char FIFO full flag.
- fifo_din  out  8  byte to char FIFO.
- fifo_wr_en  out  1  char FIFO write strobe.
- pipe_en  out  1  pipeline clock enable; the pipeline advances on edges where it is 1.
- pipe_rst  out  1  active-high synchronous reset to the pipeline.
- busy  out  1  high in any state other than IDLE and RUN.

Behaviour:
- Reset values: all outputs 0; state IDLE; edge register 0; snapshot register 0.
- Command strobe cmd_v = rx_data_rdy & ~rdy_q, where rdy_q is rx_data_rdy registered. rx_data is sampled in the cmd_v cycle.
- Command codes: 's' 8'h73 step, 'c' 8'h63 continuous run, 'p' 8'h70 pause, 'd' 8'h64 dump, 'r' 8'h72 reset. Any other byte is unknown.
- States: IDLE, RUN, STEP, LATCH, HDR, DATA, TRL, RSTP, ACK.
- IDLE, on cmd_v:
  - 's' -> STEP
  - 'c' -> RUN
  - 'd' -> LATCH
  - 'r' -> RSTP
  - 'p' -> ACK with byte 'K' (8'h4B)
  - unknown -> ACK with byte '?' (8'h3F)
- RUN:
  - pipe_en = 1 every cycle.
  - 'p' -> ACK('K'); pipe_en is 0 from the next cycle.
  - 'r' -> RSTP.
  - All other commands are dropped; state stays RUN.
- STEP: pipe_en = 1 for exactly one cycle, then -> LATCH.
- LATCH: snapshot register <= snap_in, byte index <= 0, then -> HDR. The captured snapshot therefore reflects the post-step pipeline state.
- RSTP:
  - pipe_rst = 1 and pipe_en = 0 for RST_CYCLES cycles, counted by a down-counter.
  - Then -> ACK('K').
- HDR, DATA, TRL, ACK (emit states):
  - fifo_wr_en = emit state & ~fifo_full, combinational from registered state and fifo_full.
  - fifo_din comes from a registered byte mux.
  - The state or index advances only on a cycle where fifo_wr_en = 1.
  - While fifo_full = 1, the FSM holds and fifo_din stays stable.
- HDR sends HDR_BYTE, then -> DATA.
- DATA sends NUM_WORDS*4 bytes: word 0 first, each word MSB byte first, one byte per non-full cycle. A 6-bit index stops at NUM_WORDS*4-1, then -> TRL.
- TRL sends TRL_BYTE, then -> IDLE.
- ACK sends its single byte, then -> IDLE.
- Commands arriving in STEP, LATCH, HDR, DATA, TRL, RSTP or ACK are dropped, with no queueing. rdy_q still tracks, so a held rx_data_rdy does not re-trigger.
- pipe_en is 0 in every state except RUN and STEP.
- Reset mid-operation: state returns to IDLE immediately; all outputs 0; any partial packet is abandoned.
- With fifo_full constantly 0, an 's' command produces 1 pipe_en cycle, 1 latch cycle and NUM_WORDS*4+2 consecutive write cycles.

Optional Feature:
- Macro: PIPE_DBG_CHECKSUM_EN.
- Defined:
  - A state CHK is inserted between DATA and TRL.
  - CHK emits the XOR of all DATA bytes of the current packet, accumulated as each DATA byte is written and cleared in LATCH.
  - Packet length becomes NUM_WORDS*4+3.
- Undefined: no CHK state, no accumulator; packet length is NUM_WORDS*4+2.

Test Plan:
- Reset, then 'd' with snap_in word0 = 32'h01234567, others 0, fifo_full = 0 -> FIFO receives A5,01,23,45,67, then 28 bytes of 00, then 5A on consecutive cycles; busy falls after 5A; pipe_en is never 1.
- 's' -> pipe_en high for exactly 1 cycle; LATCH samples the value snap_in carries one cycle after that pulse; a 34-byte packet follows.
- 'c', wait 100 cycles, then 'p' -> pipe_en high continuously from the cycle after 'c' until the cycle after 'p'; FIFO receives 4B only.
- During DATA, hold fifo_full = 1 for 10 cycles -> fifo_wr_en = 0 and fifo_din unchanged throughout; the stream resumes with the next byte and none are lost or duplicated.
- 'r' -> pipe_rst high exactly 4 cycles with pipe_en 0, then 4B written; byte 8'h41 -> 3F written; 's' sent mid-dump is dropped, with no extra pipe_en pulse.
- Assert rst_n low mid-DATA -> all outputs 0 asynchronously; after release, a 'd' yields a complete fresh packet. With PIPE_DBG_CHECKSUM_EN defined, the first scenario gives checksum byte 01^23^45^67 = 8'h00, placed before 5A.

Source files
------------

// File: rtl/pipe_dbg_ctrl.sv
// pipe_dbg_ctrl: UART-driven debug sequencer for the 5-stage pipeline.
// Decodes single-byte commands (s/c/p/d/r), gates the pipeline clock enable,
// drives a pipeline reset pulse and streams a framed snapshot packet
// (HDR, NUM_WORDS*4 data bytes MSB-first, TRL) into the TX char FIFO.
// Optional feature macro: PIPE_DBG_CHECKSUM_EN adds an XOR checksum byte
// between the data bytes and the trailer.
module pipe_dbg_ctrl #(
  parameter int unsigned NUM_WORDS  = 8,
  parameter int unsigned RST_CYCLES = 4,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5,
  parameter logic [7:0]  TRL_BYTE   = 8'h5A
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_rdy,
  input  logic [NUM_WORDS*32-1:0] snap_in,
  input  logic                    fifo_full,
  output logic [7:0]              fifo_din,
  output logic                    fifo_wr_en,
  output logic                    pipe_en,
  output logic                    pipe_rst,
  output logic                    busy
);

  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_PAUSE = 8'h70;
  localparam logic [7:0] CMD_DUMP  = 8'h64;
  localparam logic [7:0] CMD_RST   = 8'h72;
  localparam logic [7:0] ACK_OK    = 8'h4B;
  localparam logic [7:0] ACK_UNK   = 8'h3F;

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS*4 - 1);
  localparam logic [3:0] RST_INIT = 4'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_LATCH,
    S_HDR,
    S_DATA,
`ifdef PIPE_DBG_CHECKSUM_EN
    S_CHK,
`endif
    S_TRL,
    S_RSTP,
    S_ACK
  } state_t;

  state_t                  state_q, state_d;
  logic                    rdy_q;
  logic [NUM_WORDS*32-1:0] snap_q, snap_d;
  logic [5:0]              idx_q, idx_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [7:0]              din_q, din_d;
  logic                    pipe_en_q, pipe_rst_q, busy_q;
`ifdef PIPE_DBG_CHECKSUM_EN
  logic [7:0]              chk_q, chk_d;
`endif

  logic cmd_v;
  logic emit;

  // Byte i of the packet payload: word i/4, byte i%4 counted from the MSB.
  function automatic logic [7:0] byte_at(input logic [NUM_WORDS*32-1:0] s,
                                         input logic [5:0] i);
    logic [9:0] sa;
    sa = {1'b0, i[5:2], 5'b0} + {5'b0, ~i[1:0], 3'b0};
    return 8'(s >> sa);
  endfunction

  assign cmd_v = rx_data_rdy & ~rdy_q;

  // Emit states drive the FIFO strobe directly from the registered state.
  always_comb begin
    emit = 1'b0;
    case (state_q)
      S_HDR, S_DATA, S_TRL, S_ACK: emit = 1'b1;
`ifdef PIPE_DBG_CHECKSUM_EN
      S_CHK:                       emit = 1'b1;
`endif
      default:                     emit = 1'b0;
    endcase
  end

  assign fifo_wr_en = emit & ~fifo_full;
  assign fifo_din   = din_q;
  assign pipe_en    = pipe_en_q;
  assign pipe_rst   = pipe_rst_q;
  assign busy       = busy_q;

  // Next-state, byte mux and datapath updates; emit states advance only on a write.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
`ifdef PIPE_DBG_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_v) begin
          case (rx_data)
            CMD_STEP:  state_d = S_STEP;
            CMD_RUN:   state_d = S_RUN;
            CMD_DUMP:  state_d = S_LATCH;
            CMD_RST: begin
              state_d = S_RSTP;
              cnt_d   = RST_INIT;
            end
            CMD_PAUSE: begin
              state_d = S_ACK;
              din_d   = ACK_OK;
            end
            default: begin
              state_d = S_ACK;
              din_d   = ACK_UNK;
            end
          endcase
        end
      end
      S_RUN: begin
        if (cmd_v) begin
          if (rx_data == CMD_PAUSE) begin
            state_d = S_ACK;
            din_d   = ACK_OK;
          end else if (rx_data == CMD_RST) begin
            state_d = S_RSTP;
            cnt_d   = RST_INIT;
          end
        end
      end
      S_STEP: state_d = S_LATCH;
      S_LATCH: begin
        snap_d  = snap_in;
        idx_d   = '0;
        din_d   = HDR_BYTE;
`ifdef PIPE_DBG_CHECKSUM_EN
        chk_d   = '0;
`endif
        state_d = S_HDR;
      end
      S_HDR: begin
        if (fifo_wr_en) begin
          din_d   = byte_at(snap_q, 6'd0);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fifo_wr_en) begin
`ifdef PIPE_DBG_CHECKSUM_EN
          chk_d = chk_q ^ din_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef PIPE_DBG_CHECKSUM_EN
            // The byte leaving now is folded in here so the checksum is ready a cycle early.
            din_d   = chk_q ^ din_q;
            state_d = S_CHK;
`else
            din_d   = TRL_BYTE;
            state_d = S_TRL;
`endif
          end else begin
            idx_d = idx_q + 6'd1;
            din_d = byte_at(snap_q, idx_q + 6'd1);
          end
        end
      end
`ifdef PIPE_DBG_CHECKSUM_EN
      S_CHK: begin
        if (fifo_wr_en) begin
          din_d   = TRL_BYTE;
          state_d = S_TRL;
        end
      end
`endif
      S_TRL: begin
        if (fifo_wr_en) state_d = S_IDLE;
      end
      S_ACK: begin
        if (fifo_wr_en) state_d = S_IDLE;
      end
      S_RSTP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          din_d   = ACK_OK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (decoded from the next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rdy_q      <= 1'b0;
      snap_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      din_q      <= '0;
      pipe_en_q  <= 1'b0;
      pipe_rst_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PIPE_DBG_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rdy_q      <= rx_data_rdy;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      pipe_en_q  <= (state_d == S_RUN) || (state_d == S_STEP);
      pipe_rst_q <= (state_d == S_RSTP);
      busy_q     <= (state_d != S_IDLE) && (state_d != S_RUN);
`ifdef PIPE_DBG_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_dbg_ctrl.sv
// Testbench for pipe_dbg_ctrl: directed commands, expected FIFO bytes go into
// a queue, a negedge monitor pops and compares on every FIFO write.
module tb_pipe_dbg_ctrl;

  localparam int unsigned NW = 8;
`ifdef PIPE_DBG_CHECKSUM_EN
  localparam int unsigned PKT = NW*4 + 3;
`else
  localparam int unsigned PKT = NW*4 + 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_data_rdy;
  logic [NW*32-1:0]  snap_in;
  logic              fifo_full;
  logic [7:0]        fifo_din;
  logic              fifo_wr_en;
  logic              pipe_en;
  logic              pipe_rst;
  logic              busy;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int pe_cnt   = 0;
  int pr_cnt   = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  pipe_dbg_ctrl #(
    .NUM_WORDS (NW),
    .RST_CYCLES(4),
    .HDR_BYTE  (8'hA5),
    .TRL_BYTE  (8'h5A)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_data_rdy(rx_data_rdy),
    .snap_in    (snap_in),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .pipe_en    (pipe_en),
    .pipe_rst   (pipe_rst),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts enable/reset/busy cycles and scores every FIFO write.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (pipe_en) pe_cnt++;
      if (busy) busy_cnt++;
      if (pipe_rst) begin
        pr_cnt++;
        check("pipe_en_during_rst", {31'b0, pipe_en}, 32'd0);
      end
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h, expected no write", fifo_din);
        end else begin
          e = exp_q.pop_front();
          check("fifo_byte", {24'b0, fifo_din}, {24'b0, e});
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data     = b;
    rx_data_rdy = 1'b1;
    @(posedge clk);
    #1;
    rx_data_rdy = 1'b0;
  endtask

  // Expected packet from a snapshot value: header, words MSB-first, [checksum], trailer.
  task automatic push_dump(input logic [NW*32-1:0] s);
    logic [NW*32-1:0] t;
    logic [7:0] byt;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int w = 0; w < NW; w++) begin
      for (int b = 0; b < 4; b++) begin
        t   = s >> (w*32 + (3-b)*8);
        byt = t[7:0];
        x   = x ^ byt;
        exp_q.push_back(byt);
      end
    end
`ifdef PIPE_DBG_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    exp_q.push_back(8'h5A);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == limit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy still high after %0d cycles, expected low", name, limit);
    end
    check({name, "_queue_left"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [NW*32-1:0] s;
    logic [7:0] held;

    rst_n       = 1'b0;
    rx_data     = 8'h00;
    rx_data_rdy = 1'b0;
    snap_in     = '0;
    fifo_full   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    check("rst_fifo_din",   {24'b0, fifo_din},   32'd0);
    check("rst_pipe_en",    {31'b0, pipe_en},    32'd0);
    check("rst_pipe_rst",   {31'b0, pipe_rst},   32'd0);
    check("rst_busy",       {31'b0, busy},       32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Dump with word0 = 01234567: consecutive writes, no enable.
    s = '0;
    s[31:0] = 32'h01234567;
    snap_in = s;
    push_dump(s);
    pe_cnt = 0; busy_cnt = 0;
    send_cmd(8'h64);
    wait_idle("dump1", 200);
    check("dump1_busy_cycles", busy_cnt, PKT + 1);
    check("dump1_pipe_en_cycles", pe_cnt, 32'd0);

    // Step: one enable pulse, snapshot taken the cycle after the pulse.
    s = '0;
    s[31:0]    = 32'hCAFEF00D;
    s[255:224] = 32'h89ABCDEF;
    push_dump(s);
    pe_cnt = 0; busy_cnt = 0;
    send_cmd(8'h73);
    snap_in = {NW{32'hDEADBEEF}};
    @(posedge clk);
    #1 snap_in = s;
    @(posedge clk);
    #1 snap_in = {NW{32'hFFFFFFFF}};
    wait_idle("step", 200);
    check("step_pipe_en_cycles", pe_cnt, 32'd1);
    check("step_busy_cycles", busy_cnt, PKT + 2);

    // Continuous run, then pause.
    pe_cnt = 0;
    send_cmd(8'h63);
    repeat (100) @(posedge clk);
    exp_q.push_back(8'h4B);
    send_cmd(8'h70);
    wait_idle("run_pause", 20);
    check("run_pipe_en_cycles", pe_cnt, 32'd102);
    check("run_pipe_en_after", {31'b0, pipe_en}, 32'd0);

    // FIFO full held for 10 cycles mid-DATA.
    s = '0;
    for (int w = 0; w < NW; w++) s[w*32 +: 32] = 32'h10203040 + w;
    snap_in = s;
    push_dump(s);
    busy_cnt = 0;
    send_cmd(8'h64);
    repeat (5) @(posedge clk);
    #1 fifo_full = 1'b1;
    @(negedge clk);
    held = fifo_din;
    check("full_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    repeat (9) begin
      @(negedge clk);
      check("full_wr_en", {31'b0, fifo_wr_en}, 32'd0);
      check("full_din_stable", {24'b0, fifo_din}, {24'b0, held});
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_idle("full", 200);
    check("full_busy_cycles", busy_cnt, PKT + 11);

    // Pipeline reset command.
    pe_cnt = 0; pr_cnt = 0; busy_cnt = 0;
    exp_q.push_back(8'h4B);
    send_cmd(8'h72);
    wait_idle("rstcmd", 40);
    check("rstcmd_pipe_rst_cycles", pr_cnt, 32'd4);
    check("rstcmd_pipe_en_cycles", pe_cnt, 32'd0);
    check("rstcmd_busy_cycles", busy_cnt, 32'd5);

    // Unknown command byte.
    exp_q.push_back(8'h3F);
    send_cmd(8'h41);
    wait_idle("unknown", 20);

    // Step command issued mid-dump is dropped.
    s = '0;
    s[63:32] = 32'hA1B2C3D4;
    snap_in = s;
    push_dump(s);
    pe_cnt = 0; busy_cnt = 0;
    send_cmd(8'h64);
    repeat (5) @(posedge clk);
    send_cmd(8'h73);
    wait_idle("drop", 200);
    check("drop_pipe_en_cycles", pe_cnt, 32'd0);
    check("drop_busy_cycles", busy_cnt, PKT + 1);

    // Asynchronous reset mid-DATA, then a fresh dump.
    s = {NW{32'h55AA0FF0}};
    snap_in = s;
    push_dump(s);
    send_cmd(8'h64);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_fifo_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    check("async_fifo_din",   {24'b0, fifo_din},   32'd0);
    check("async_pipe_en",    {31'b0, pipe_en},    32'd0);
    check("async_pipe_rst",   {31'b0, pipe_rst},   32'd0);
    check("async_busy",       {31'b0, busy},       32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    s = '0;
    s[31:0] = 32'h01234567;
    s[95:64] = 32'hFEDCBA98;
    snap_in = s;
    push_dump(s);
    busy_cnt = 0;
    send_cmd(8'h64);
    wait_idle("after_rst", 200);
    check("after_rst_busy_cycles", busy_cnt, PKT + 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
